// File: rtl/kgp_fetch_unit.sv
// KGP-RISC fetch stage: owns the PC, fetches over a req/rvalid handshake and
// resolves the decoder's next-PC selection, including a circular return-address stack.
module kgp_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          RAS_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pc_control,
    input  logic        is_call,
    input  logic [31:0] reg_target,
    input  logic [25:0] imm26,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        ras_overflow,
    output logic        ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = 1;
    localparam logic [PTR_W:0]   COUNT_ONE  = 1;
    localparam logic [PTR_W:0]   COUNT_FULL = RAS_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t           state;
    logic [31:0]      ras [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_count;
    logic [PTR_W-1:0] top_idx;
    logic [31:0]      branch_target;
    logic [31:0]      next_pc;
    logic             do_push;
    logic             do_pop;
    logic             pop_empty;
    logic             unused_low_bits;

    assign pc_plus4        = pc + 32'd4;
    assign imem_addr       = pc;
    assign top_idx         = ras_ptr - PTR_ONE;
    assign branch_target   = pc_plus4 + {{4{imm26[25]}}, imm26, 2'b00};
    // BR targets are forced word-aligned, so the low rs bits are discarded.
    assign unused_low_bits = ^reg_target[1:0];

    always_comb begin
        next_pc   = pc_plus4;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        pop_empty = 1'b0;
        case (pc_control)
            4'd1: next_pc = {reg_target[31:2], 2'b00};
            4'd2: begin
                next_pc = branch_target;
                do_push = is_call;
            end
            4'd3: begin
                if (ras_count == '0) begin
                    pop_empty = 1'b1;
                end else begin
                    next_pc = ras[top_idx];
                    do_pop  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            instr         <= '0;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b0;
            ras_ptr       <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                        // A full stack keeps its count; the write pointer then lands on the oldest entry.
                        if (do_push) begin
                            ras_ptr <= ras_ptr + PTR_ONE;
                            if (ras_count == COUNT_FULL) begin
                                ras_overflow <= 1'b1;
                            end else begin
                                ras_count <= ras_count + COUNT_ONE;
                            end
                        end
                        if (do_pop) begin
                            ras_ptr   <= top_idx;
                            ras_count <= ras_count - COUNT_ONE;
                        end
                        if (pop_empty) begin
                            ras_underflow <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == EXEC && !stall && do_push) begin
            ras[ras_ptr] <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Directed bench for kgp_fetch_unit: a small memory model with programmable latency
// feeds the fetch unit while the bench plays the decoder.
module tb_kgp_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pc_control = 4'd0;
    logic        is_call = 1'b0;
    logic [31:0] reg_target = 32'd0;
    logic [25:0] imm26 = 26'd0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ras_overflow;
    logic        ras_underflow;

    int          mem_latency = 0;
    int          wait_cnt = 0;
    logic        force_rvalid = 1'b0;
    logic [31:0] mem_data = 32'h0000_0020;
    int          passed = 0;
    int          total = 0;

    kgp_fetch_unit #(.RESET_PC(32'h0000_0000), .RAS_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_control   (pc_control),
        .is_call      (is_call),
        .reg_target   (reg_target),
        .imm26        (imm26),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    // Memory answers after mem_latency extra cycles of an outstanding request.
    assign imem_rvalid = (imem_req && wait_cnt == mem_latency) || force_rvalid;
    assign imem_rdata  = mem_data;

    always @(posedge clk) begin
        if (rst || !imem_req || imem_rvalid) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total = total + 1;
        assert (observed === expected) passed = passed + 1;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    endtask

    // Waits for the EXEC cycle, presents one decoder result, and returns in the following FETCH cycle.
    task automatic apply_stimulus(input logic [3:0] ctl, input logic call,
                                  input logic [31:0] tgt, input logic [25:0] imm);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("wait_valid", {31'd0, instr_valid}, 32'd1);
        pc_control = ctl;
        is_call    = call;
        reg_target = tgt;
        imm26      = imm;
        @(negedge clk);
        pc_control = 4'd0;
        is_call    = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_output("rst_req", {31'd0, imem_req}, 32'd0);
        check_output("rst_addr", imem_addr, 32'h0);
        check_output("rst_ovf", {31'd0, ras_overflow}, 32'd0);
        check_output("rst_unf", {31'd0, ras_underflow}, 32'd0);
        rst = 1'b0;

        $display("[TB] sequential fetch, zero-wait memory");
        @(negedge clk);
        check_output("f0_req", {31'd0, imem_req}, 32'd1);
        check_output("f0_addr", imem_addr, 32'h0);
        check_output("f0_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_output("e0_valid", {31'd0, instr_valid}, 32'd1);
        check_output("e0_instr", instr, 32'h0000_0020);
        check_output("e0_req", {31'd0, imem_req}, 32'd0);
        check_output("e0_pc4", pc_plus4, 32'h4);
        @(negedge clk);
        check_output("f1_addr", imem_addr, 32'h4);
        check_output("f1_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check_output("e1_valid", {31'd0, instr_valid}, 32'd1);
        check_output("e1_pc", pc, 32'h4);
        @(negedge clk);
        check_output("f2_addr", imem_addr, 32'h8);
        check_output("f2_valid", {31'd0, instr_valid}, 32'd0);

        $display("[TB] branches");
        apply_stimulus(4'd1, 1'b0, 32'h0000_0103, 26'd0);
        check_output("br_addr", imem_addr, 32'h100);
        apply_stimulus(4'd2, 1'b0, 32'd0, 26'h3FF_FFFE);
        check_output("bneg_addr", imem_addr, 32'h0FC);
        apply_stimulus(4'd15, 1'b1, 32'd0, 26'h10);
        check_output("code15_addr", imem_addr, 32'h100);
        check_output("code15_ras", 32'(dut.ras_count), 32'd0);
        apply_stimulus(4'd1, 1'b0, 32'h0000_0040, 26'd0);
        check_output("br40_addr", imem_addr, 32'h40);

        $display("[TB] call and return");
        apply_stimulus(4'd2, 1'b1, 32'd0, 26'h10);
        check_output("call_addr", imem_addr, 32'h84);
        check_output("call_ras", 32'(dut.ras_count), 32'd1);
        apply_stimulus(4'd3, 1'b0, 32'd0, 26'd0);
        check_output("ret_addr", imem_addr, 32'h44);
        check_output("ret_ras", 32'(dut.ras_count), 32'd0);
        check_output("ret_unf", {31'd0, ras_underflow}, 32'd0);

        $display("[TB] nested calls past the stack depth");
        for (int k = 1; k <= 9; k++) begin
            apply_stimulus(4'd2, 1'b1, 32'd0, 26'h10);
            check_output("nest_addr", imem_addr, 32'(68 * (k + 1)));
            if (k == 8) check_output("ovf_at8", {31'd0, ras_overflow}, 32'd0);
        end
        check_output("ovf_at9", {31'd0, ras_overflow}, 32'd1);
        check_output("full_ras", 32'(dut.ras_count), 32'd8);
        for (int k = 9; k >= 2; k--) begin
            apply_stimulus(4'd3, 1'b0, 32'd0, 26'd0);
            check_output("nest_ret", imem_addr, 32'(68 * k + 4));
        end
        check_output("unf_before", {31'd0, ras_underflow}, 32'd0);
        apply_stimulus(4'd3, 1'b0, 32'd0, 26'd0);
        check_output("ret_empty_addr", imem_addr, 32'h90);
        check_output("unf_after", {31'd0, ras_underflow}, 32'd1);

        $display("[TB] slow memory and stall");
        mem_latency = 2;
        mem_data    = 32'hABCD_1234;
        for (int i = 0; i < 3; i++) begin
            check_output("lat_req", {31'd0, imem_req}, 32'd1);
            check_output("lat_addr", imem_addr, 32'h90);
            check_output("lat_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
        end
        check_output("lat_exec_valid", {31'd0, instr_valid}, 32'd1);
        check_output("lat_exec_instr", instr, 32'hABCD_1234);
        stall      = 1'b1;
        pc_control = 4'd2;
        imm26      = 26'h4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_output("stall_pc", pc, 32'h90);
            check_output("stall_instr", instr, 32'hABCD_1234);
            check_output("stall_valid", {31'd0, instr_valid}, 32'd1);
            check_output("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        @(negedge clk);
        pc_control = 4'd0;
        check_output("upd_pc", pc, 32'hA4);
        check_output("upd_valid", {31'd0, instr_valid}, 32'd0);
        check_output("upd_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        check_output("hold_pc", pc, 32'hA4);

        $display("[TB] reset during fetch with stale response");
        rst = 1'b1;
        @(negedge clk);
        check_output("rst2_req", {31'd0, imem_req}, 32'd0);
        check_output("rst2_pc", pc, 32'h0);
        check_output("rst2_valid", {31'd0, instr_valid}, 32'd0);
        rst          = 1'b0;
        force_rvalid = 1'b1;
        mem_data     = 32'hDEAD_BEEF;
        @(negedge clk);
        force_rvalid = 1'b0;
        check_output("stale_valid", {31'd0, instr_valid}, 32'd0);
        check_output("stale_instr", instr, 32'h0);
        check_output("stale_req", {31'd0, imem_req}, 32'd1);
        check_output("stale_addr", imem_addr, 32'h0);
        check_output("stale_ovf", {31'd0, ras_overflow}, 32'd0);
        check_output("stale_unf", {31'd0, ras_underflow}, 32'd0);
        mem_latency = 0;
        mem_data    = 32'h0000_0020;
        @(negedge clk);
        check_output("post_valid", {31'd0, instr_valid}, 32'd1);
        check_output("post_instr", instr, 32'h0000_0020);
        check_output("post_pc", pc, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
